// File: rtl/countdown_timer.sv
// MM:SS countdown timer with load clamping, pause/resume, a minute-borrow pulse and a done pulse.
// Define COUNTDOWN_AUTORELOAD_EN to restart from the last loaded value on expiry instead of stopping in DONE.
module countdown_timer #(
  parameter int MIN_MAX = 59,
  parameter int SEC_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       bz,
  output logic       done
);

  localparam logic [5:0] MIN_LIM = 6'(MIN_MAX);
  localparam logic [5:0] SEC_LIM = 6'(SEC_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t     state;
  logic [5:0] rl_min, rl_sec;
  logic [5:0] clamp_min, clamp_sec;
  logic [5:0] dec_min, dec_sec;
  logic       borrow, expire, nonzero;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    clamp_min = (load_min > MIN_LIM) ? MIN_LIM : load_min;
    clamp_sec = (load_sec > SEC_LIM) ? SEC_LIM : load_sec;
    nonzero   = (min != 6'd0) || (sec != 6'd0);
    dec_min   = min;
    dec_sec   = sec;
    borrow    = 1'b0;
    if (sec != 6'd0) begin
      dec_sec = sec - 6'd1;
    end else if (min != 6'd0) begin
      dec_sec = SEC_LIM;
      dec_min = min - 6'd1;
      borrow  = 1'b1;
    end
    expire = nonzero && (dec_min == 6'd0) && (dec_sec == 6'd0);
  end

  assign running = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      min    <= 6'd0;
      sec    <= 6'd0;
      rl_min <= 6'd0;
      rl_sec <= 6'd0;
      bz     <= 1'b0;
      done   <= 1'b0;
    end else begin
      bz   <= 1'b0;
      done <= 1'b0;
      if (load) begin
        min    <= clamp_min;
        sec    <= clamp_sec;
        rl_min <= clamp_min;
        rl_sec <= clamp_sec;
        state  <= IDLE;
      end else begin
        case (state)
          RUN: begin
            if (stop) begin
              state <= PAUSE;
            end else if (tick && nonzero) begin
              bz <= borrow;
              if (expire) begin
                done <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                min <= rl_min;
                sec <= rl_sec;
                if ((rl_min == 6'd0) && (rl_sec == 6'd0)) state <= IDLE;
`else
                min   <= 6'd0;
                sec   <= 6'd0;
                state <= DONE;
`endif
              end else begin
                min <= dec_min;
                sec <= dec_sec;
              end
            end
          end
          // IDLE, PAUSE and DONE all resume on start, provided there is time left.
          default: begin
            if (start && nonzero) state <= RUN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios followed by random stimulus,
// compared every cycle against a model that tracks the remaining time as a plain seconds total.
module tb_countdown_timer;

  localparam int MIN_MAX = 59;
  localparam int SEC_MAX = 59;
  localparam int SPM     = SEC_MAX + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, load = 1'b0, start = 1'b0, stop = 1'b0;
  logic [5:0] load_min = 6'd0, load_sec = 6'd0;
  logic [5:0] min, sec;
  logic       running, bz, done;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining time and reload value in seconds, plus a running flag.
  int t_rem = 0, t_rl = 0;
  bit m_run = 0, e_bz = 0, e_done = 0;

  countdown_timer #(.MIN_MAX(MIN_MAX), .SEC_MAX(SEC_MAX)) dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .stop(stop), .min(min), .sec(sec), .running(running), .bz(bz), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ":min"},     {26'd0, min},     t_rem / SPM);
    chk({where, ":sec"},     {26'd0, sec},     t_rem % SPM);
    chk({where, ":running"}, {31'd0, running}, {31'd0, m_run});
    chk({where, ":bz"},      {31'd0, bz},      {31'd0, e_bz});
    chk({where, ":done"},    {31'd0, done},    {31'd0, e_done});
  endtask

  task automatic model_reset();
    t_rem = 0; t_rl = 0; m_run = 0; e_bz = 0; e_done = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_edge(input bit tk, input bit ld, input int lm, input int ls,
                            input bit st, input bit sp);
    e_bz = 0;
    e_done = 0;
    if (ld) begin
      t_rem = ((lm > MIN_MAX) ? MIN_MAX : lm) * SPM + ((ls > SEC_MAX) ? SEC_MAX : ls);
      t_rl  = t_rem;
      m_run = 0;
    end else if (m_run) begin
      if (sp) begin
        m_run = 0;
      end else if (tk && t_rem > 0) begin
        e_bz  = (t_rem % SPM == 0);
        t_rem = t_rem - 1;
        if (t_rem == 0) begin
          e_done = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
          t_rem = t_rl;
          if (t_rl == 0) m_run = 0;
`else
          m_run = 0;
`endif
        end
      end
    end else if (st && t_rem > 0) begin
      m_run = 1;
    end
  endtask

  task automatic step(input string where, input bit tk, input bit ld, input int lm,
                      input int ls, input bit st, input bit sp);
    tick = tk; load = ld; load_min = 6'(lm); load_sec = 6'(ls); start = st; stop = sp;
    @(posedge clk);
    model_edge(tk, ld, lm, ls, st, sp);
    #1;
    check_all(where);
  endtask

  initial begin
    #1;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    check_all("reset_release");

    // Zero start is ignored; load beats a simultaneous start.
    step("zero_start", 0, 0, 0, 0, 1, 0);
    chk("zero_start_direct", {31'd0, running}, 32'd0);
    step("load_vs_start", 0, 1, 0, 5, 1, 0);
    chk("load_vs_start_direct", {31'd0, running}, 32'd0);

    // Load clamp.
    step("clamp", 0, 1, 63, 63, 0, 0);
    chk("clamp_min_direct", {26'd0, min}, 32'd59);
    chk("clamp_sec_direct", {26'd0, sec}, 32'd59);

    // Minute borrow.
    step("borrow_load", 0, 1, 1, 0, 0, 0);
    step("borrow_start", 0, 0, 0, 0, 1, 0);
    step("borrow_tick", 1, 0, 0, 0, 0, 0);
    chk("borrow_bz_direct", {31'd0, bz}, 32'd1);
    step("borrow_after", 0, 0, 0, 0, 0, 0);

    // Expiry, then extra ticks.
    step("exp_load", 0, 1, 0, 2, 0, 0);
    step("exp_start", 0, 0, 0, 0, 1, 0);
    step("exp_tick1", 1, 0, 0, 0, 0, 0);
    step("exp_tick2", 1, 0, 0, 0, 0, 0);
    chk("exp_done_direct", {31'd0, done}, 32'd1);
    for (int i = 0; i < 3; i++) step("exp_more", 1, 0, 0, 0, 0, 0);

    // Pause on stop+tick, then resume.
    step("pr_load", 0, 1, 0, 10, 0, 0);
    step("pr_start", 0, 0, 0, 0, 1, 0);
    step("pr_stop_tick", 1, 0, 0, 0, 1, 1);
    chk("pr_sec_hold_direct", {26'd0, sec}, 32'd10);
    step("pr_paused_tick", 1, 0, 0, 0, 0, 0);
    step("pr_resume", 0, 0, 0, 0, 1, 0);
    step("pr_tick", 1, 0, 0, 0, 0, 0);
    chk("pr_sec_dec_direct", {26'd0, sec}, 32'd9);

    // Reset mid-count: takes effect before the next edge and clears the reload value.
    step("rm_load", 0, 1, 5, 30, 0, 0);
    step("rm_start", 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("rm_tick", 1, 0, 0, 0, 0, 0);
    tick = 0; load = 0; start = 0; stop = 0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("rm_async");
    #1 rst = 1'b0;
    step("rm_start_ignored", 0, 0, 0, 0, 1, 0);
    step("rm_tick_ignored", 1, 0, 0, 0, 0, 0);

    // Random stimulus: short loads so expiry and borrows happen often.
    for (int i = 0; i < 600; i++) begin
      int lm, ls;
      lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 2));
      ls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 4));
      step("rand", ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0), lm, ls,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
